// File: rtl/mem_0_pkg.sv
// Shared constants and the m0->m1 pipeline record used by the mem_0 stage
// (bubble values are also consumed by Mem_1).
package mem_0_pkg;

    localparam int DATA_ADDR_BITS = 9;
    localparam logic [4:0] REG_ZERO = 5'd0;

    typedef struct packed {
        logic        oper;
        logic        readmem;
        logic        writemem;
        logic        writereg;
        logic [31:0] data_addr;
        logic [31:0] regb;
        logic [4:0]  regdest;
    } m0_m1_t;

    localparam logic [31:0] BUBBLE_ADDR    = 32'd0;
    localparam logic [31:0] BUBBLE_REGB    = 32'd0;
    localparam logic [4:0]  BUBBLE_REGDEST = REG_ZERO;
    localparam m0_m1_t M0_M1_BUBBLE = '{
        oper:      1'b0,
        readmem:   1'b0,
        writemem:  1'b0,
        writereg:  1'b0,
        data_addr: BUBBLE_ADDR,
        regb:      BUBBLE_REGB,
        regdest:   BUBBLE_REGDEST
    };

endpackage

// File: rtl/mem_addr_check.sv
// Combinational classifier for data-memory addresses: flags word-misaligned
// and out-of-range accesses of a valid load/store.
module mem_addr_check
    import mem_0_pkg::*;
#(
    parameter int ADDR_BITS = DATA_ADDR_BITS
) (
    input  logic        oper,
    input  logic        readmem,
    input  logic        writemem,
    input  logic [31:0] addr,
    output logic        misaligned,
    output logic        out_of_range,
    output logic        fault
);

    logic mem_op;

    assign mem_op       = oper & (readmem | writemem);
    assign misaligned   = mem_op & (addr[1:0] != 2'b00);
    assign out_of_range = mem_op & (addr[31:ADDR_BITS] != '0);
    assign fault        = misaligned | out_of_range;

endmodule

// File: rtl/mem_0.sv
// First memory pipeline stage: registers the execute request for Mem_1,
// turns faulting accesses into bubbles with a trap record, and drives the load-use interlock.
module mem_0
    import mem_0_pkg::*;
#(
    parameter int ADDR_BITS   = DATA_ADDR_BITS,
    parameter int STALL_CNT_W = 16
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   ex_m0_oper,
    input  logic                   ex_m0_readmem,
    input  logic                   ex_m0_writemem,
    input  logic [31:0]            ex_m0_alu_result,
    input  logic [31:0]            ex_m0_regb,
    input  logic [4:0]             ex_m0_regdest,
    input  logic                   ex_m0_writereg,
    input  logic [4:0]             id_ex_rs,
    input  logic [4:0]             id_ex_rt,
    input  logic                   exc_clear,
    output logic                   m0_m1_oper,
    output logic                   m0_m1_readmem,
    output logic                   m0_m1_writemem,
    output logic                   m0_m1_writereg,
    output logic [31:0]            m0_m1_data_addr,
    output logic [31:0]            m0_m1_regb,
    output logic [4:0]             m0_m1_regdest,
    output logic                   m0_ex_stall,
    output logic                   m0_exc_valid,
    output logic                   m0_exc_sticky,
    output logic [31:0]            m0_exc_addr,
    output logic                   m0_exc_store,
    output logic [STALL_CNT_W-1:0] m0_stall_count
);

    logic misaligned, out_of_range, fault;

    mem_addr_check #(
        .ADDR_BITS (ADDR_BITS)
    ) u_addr_check (
        .oper         (ex_m0_oper),
        .readmem      (ex_m0_readmem),
        .writemem     (ex_m0_writemem),
        .addr         (ex_m0_alu_result),
        .misaligned   (misaligned),
        .out_of_range (out_of_range),
        .fault        (fault)
    );

    m0_m1_t                 pipe_q, pipe_d;
    logic                   exc_valid_q, exc_valid_d;
    logic                   exc_sticky_q, exc_sticky_d;
    logic [31:0]            exc_addr_q, exc_addr_d;
    logic                   exc_store_q, exc_store_d;
    logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    logic stall, capture, trap, store_req;

    assign stall = pipe_q.oper & pipe_q.readmem & pipe_q.writereg
                 & (pipe_q.regdest != REG_ZERO)
                 & ((pipe_q.regdest == id_ex_rs) | (pipe_q.regdest == id_ex_rt));

    // A request carrying both load and store is executed as a load only.
    assign store_req = ex_m0_writemem & ~ex_m0_readmem;
    // While stalled, execute is holding and its request will be re-presented.
    assign capture   = ex_m0_oper & ~fault & ~stall;
    assign trap      = fault & ~stall;

    always_comb begin
        pipe_d = M0_M1_BUBBLE;
        if (capture) begin
            pipe_d.oper      = 1'b1;
            pipe_d.readmem   = ex_m0_readmem;
            pipe_d.writemem  = store_req;
            pipe_d.writereg  = ex_m0_writereg;
            pipe_d.data_addr = ex_m0_alu_result;
            pipe_d.regb      = ex_m0_regb;
            pipe_d.regdest   = ex_m0_regdest;
        end
    end

    always_comb begin
        exc_valid_d  = trap;
        exc_sticky_d = exc_sticky_q;
        exc_addr_d   = exc_addr_q;
        exc_store_d  = exc_store_q;
        if (trap) begin
            exc_sticky_d = 1'b1;
            exc_addr_d   = ex_m0_alu_result;
            exc_store_d  = store_req;
        end else if (exc_clear) begin
            exc_sticky_d = 1'b0;
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + STALL_CNT_W'(1);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pipe_q       <= M0_M1_BUBBLE;
            exc_valid_q  <= 1'b0;
            exc_sticky_q <= 1'b0;
            exc_addr_q   <= 32'd0;
            exc_store_q  <= 1'b0;
            stall_cnt_q  <= '0;
        end else begin
            pipe_q       <= pipe_d;
            exc_valid_q  <= exc_valid_d;
            exc_sticky_q <= exc_sticky_d;
            exc_addr_q   <= exc_addr_d;
            exc_store_q  <= exc_store_d;
            stall_cnt_q  <= stall_cnt_d;
        end
    end

    assign m0_m1_oper      = pipe_q.oper;
    assign m0_m1_readmem   = pipe_q.readmem;
    assign m0_m1_writemem  = pipe_q.writemem;
    assign m0_m1_writereg  = pipe_q.writereg;
    assign m0_m1_data_addr = pipe_q.data_addr;
    assign m0_m1_regb      = pipe_q.regb;
    assign m0_m1_regdest   = pipe_q.regdest;
    assign m0_ex_stall     = stall;
    assign m0_exc_valid    = exc_valid_q;
    assign m0_exc_sticky   = exc_sticky_q;
    assign m0_exc_addr     = exc_addr_q;
    assign m0_exc_store    = exc_store_q;
    assign m0_stall_count  = stall_cnt_q;

endmodule

// File: tb/tb_mem_0.sv
// Bench for mem_0: directed scenarios followed by random traffic, both checked
// against a cycle-level behavioural model; a second instance uses a 2-bit stall counter.
module tb_mem_0;

    localparam int ADDR_BITS = 9;

    logic        clock = 1'b0;
    logic        reset;
    logic        oper, rd, wr, wreg, clr;
    logic [31:0] alu, regb;
    logic [4:0]  dest, rs, rt;

    logic        o_oper, o_rd, o_wr, o_wreg, o_stall, o_exv, o_sticky, o_store;
    logic [31:0] o_addr, o_regb, o_exaddr;
    logic [4:0]  o_dest;
    logic [15:0] o_cnt;

    logic        s_oper, s_rd, s_wr, s_wreg, s_stall, s_exv, s_sticky, s_store;
    logic [31:0] s_addr, s_regb, s_exaddr;
    logic [4:0]  s_dest;
    logic [1:0]  s_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clock = ~clock;

    mem_0 #(.ADDR_BITS(ADDR_BITS), .STALL_CNT_W(16)) dut (
        .clock(clock), .reset(reset),
        .ex_m0_oper(oper), .ex_m0_readmem(rd), .ex_m0_writemem(wr),
        .ex_m0_alu_result(alu), .ex_m0_regb(regb), .ex_m0_regdest(dest),
        .ex_m0_writereg(wreg), .id_ex_rs(rs), .id_ex_rt(rt), .exc_clear(clr),
        .m0_m1_oper(o_oper), .m0_m1_readmem(o_rd), .m0_m1_writemem(o_wr),
        .m0_m1_writereg(o_wreg), .m0_m1_data_addr(o_addr), .m0_m1_regb(o_regb),
        .m0_m1_regdest(o_dest), .m0_ex_stall(o_stall), .m0_exc_valid(o_exv),
        .m0_exc_sticky(o_sticky), .m0_exc_addr(o_exaddr), .m0_exc_store(o_store),
        .m0_stall_count(o_cnt)
    );

    mem_0 #(.ADDR_BITS(ADDR_BITS), .STALL_CNT_W(2)) dut_sat (
        .clock(clock), .reset(reset),
        .ex_m0_oper(oper), .ex_m0_readmem(rd), .ex_m0_writemem(wr),
        .ex_m0_alu_result(alu), .ex_m0_regb(regb), .ex_m0_regdest(dest),
        .ex_m0_writereg(wreg), .id_ex_rs(rs), .id_ex_rt(rt), .exc_clear(clr),
        .m0_m1_oper(s_oper), .m0_m1_readmem(s_rd), .m0_m1_writemem(s_wr),
        .m0_m1_writereg(s_wreg), .m0_m1_data_addr(s_addr), .m0_m1_regb(s_regb),
        .m0_m1_regdest(s_dest), .m0_ex_stall(s_stall), .m0_exc_valid(s_exv),
        .m0_exc_sticky(s_sticky), .m0_exc_addr(s_exaddr), .m0_exc_store(s_store),
        .m0_stall_count(s_cnt)
    );

    typedef struct {
        bit        oper, rd, wr, wreg;
        bit [31:0] addr, regb;
        bit [4:0]  dest;
        bit        exv, sticky, store;
        bit [31:0] exaddr;
        int        cnt, cnt_sat;
    } model_t;

    model_t m;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic bit model_stall();
        return m.oper && m.rd && m.wreg && (m.dest != 0) && (m.dest == rs || m.dest == rt);
    endfunction

    task automatic model_reset();
        m = '{default: 0};
    endtask

    task automatic check_all();
        chk("oper",     o_oper,   m.oper);
        chk("readmem",  o_rd,     m.rd);
        chk("writemem", o_wr,     m.wr);
        chk("writereg", o_wreg,   m.wreg);
        chk("addr",     o_addr,   m.addr);
        chk("regb",     o_regb,   m.regb);
        chk("regdest",  o_dest,   m.dest);
        chk("stall",    o_stall,  model_stall());
        chk("exc_valid", o_exv,   m.exv);
        chk("sticky",   o_sticky, m.sticky);
        chk("exc_addr", o_exaddr, m.exaddr);
        chk("exc_store", o_store, m.store);
        chk("stall_cnt", o_cnt,   32'(m.cnt));
        chk("stall_cnt_sat", s_cnt, 32'(m.cnt_sat));
    endtask

    // Check at the falling edge, then advance the model across the rising edge.
    task automatic cycle();
        model_t n;
        bit     stalled, memop, bad;
        @(negedge clock);
        check_all();
        stalled = model_stall();
        memop   = oper && (rd || wr);
        bad     = memop && ((alu % 4) != 0 || longint'(alu) >= (longint'(1) << ADDR_BITS));
        n = m;
        if (oper && !stalled && !bad) begin
            n.oper = 1; n.rd = rd; n.wr = wr && !rd; n.wreg = wreg;
            n.addr = alu; n.regb = regb; n.dest = dest;
        end else begin
            n.oper = 0; n.rd = 0; n.wr = 0; n.wreg = 0;
            n.addr = 0; n.regb = 0; n.dest = 0;
        end
        n.exv = bad && !stalled;
        if (n.exv) begin
            n.sticky = 1; n.exaddr = alu; n.store = wr && !rd;
        end else if (clr) begin
            n.sticky = 0;
        end
        if (stalled) begin
            if (n.cnt < 65535) n.cnt++;
            if (n.cnt_sat < 3) n.cnt_sat++;
        end
        @(posedge clock);
        m = n;
        #1;
    endtask

    task automatic drive(input bit o, input bit r, input bit w, input bit [31:0] a,
                         input bit [4:0] d, input bit wg);
        oper = o; rd = r; wr = w; alu = a; dest = d; wreg = wg; regb = $urandom;
    endtask

    initial begin
        reset = 1'b1;
        drive(0, 0, 0, 0, 0, 0);
        rs = 0; rt = 0; clr = 0;
        model_reset();
        repeat (2) @(posedge clock);
        #1;
        check_all();
        reset = 1'b0;

        // Load at 0x10 to r5, then a consumer of r5.
        drive(1, 1, 0, 32'h10, 5, 1);
        cycle();
        chk("ld_addr", o_addr, 32'h10);
        chk("ld_readmem", o_rd, 1);
        drive(1, 0, 0, 32'h44, 7, 1);
        rs = 5;
        #1 chk("ld_use_stall", o_stall, 1);
        cycle();
        chk("ld_use_cnt", o_cnt, 1);
        chk("ld_use_bubble", o_oper, 0);
        chk("ld_use_stall_gone", o_stall, 0);
        rs = 0;

        // Misaligned store.
        drive(1, 0, 1, 32'h6, 3, 0);
        cycle();
        chk("st_bubble_oper", o_oper, 0);
        chk("st_bubble_wm", o_wr, 0);
        chk("st_exc_valid", o_exv, 1);
        chk("st_exc_addr", o_exaddr, 32'h6);
        chk("st_exc_store", o_store, 1);
        chk("st_sticky", o_sticky, 1);
        drive(0, 0, 0, 0, 0, 0);
        cycle();
        chk("st_exc_pulse_end", o_exv, 0);

        // Out-of-range load, then clear racing a new fault.
        drive(1, 1, 0, 32'h200, 4, 1);
        cycle();
        chk("oor_exc_valid", o_exv, 1);
        chk("oor_exc_store", o_store, 0);
        drive(1, 1, 0, 32'h201, 4, 1);
        clr = 1;
        cycle();
        chk("clr_set_wins", o_sticky, 1);
        chk("clr_exc_addr", o_exaddr, 32'h201);
        drive(0, 0, 0, 0, 0, 0);
        cycle();
        clr = 0;
        chk("clr_sticky", o_sticky, 0);

        // Load to r0 never interlocks; non-memory op with odd result passes.
        drive(1, 1, 0, 32'h20, 0, 1);
        rs = 0;
        cycle();
        drive(1, 0, 0, 32'h3, 6, 1);
        #1 chk("r0_no_stall", o_stall, 0);
        cycle();
        chk("alu_no_trap", o_exv, 0);
        chk("alu_pass_oper", o_oper, 1);
        chk("alu_pass_addr", o_addr, 32'h3);

        // Four more load-use stalls: 5 total.
        repeat (4) begin
            drive(1, 1, 0, 32'h30, 5, 1);
            rs = 0;
            cycle();
            drive(1, 0, 0, 32'h0, 1, 1);
            rs = 5;
            cycle();
        end
        rs = 0;
        chk("cnt_five", o_cnt, 5);
        chk("cnt_saturated", s_cnt, 3);

        // Asynchronous reset in the middle of a stall.
        drive(1, 1, 0, 32'h50, 5, 1);
        cycle();
        drive(1, 0, 0, 32'h8, 2, 1);
        rs = 5;
        #1 chk("pre_reset_stall", o_stall, 1);
        reset = 1'b1;
        #1;
        model_reset();
        check_all();
        reset = 1'b0;
        drive(1, 1, 0, 32'h40, 2, 1);
        rs = 0;
        cycle();
        chk("post_reset_addr", o_addr, 32'h40);
        chk("post_reset_rd", o_rd, 1);

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            bit [31:0] a;
            case ($urandom % 4)
                0, 3:    a = {23'd0, 7'($urandom), 2'b00};
                1:       a = {23'd0, 7'($urandom), 2'($urandom_range(1, 3))};
                default: a = $urandom | 32'h200;
            endcase
            drive(($urandom % 8) != 0, $urandom % 2, $urandom % 2, a,
                  5'($urandom % 8), $urandom % 2);
            rs  = 5'($urandom % 8);
            rt  = 5'($urandom % 8);
            clr = ($urandom % 8) == 0;
            cycle();
        end
        @(negedge clock);
        check_all();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
